// File: rtl/factor_judge_if.sv
// factor_judge_if: player-facing bundle of the answer checker.
//   master side (digit-entry front end / bench) drives DEC and D1..D3,
//   slave side (factor_judge) drives RESULT, STATE, TARGET, SCORE, BUSY.
//   DEC           decide strobe
//   D1, D2, D3    latched player digits, legal range 1..9
//   RESULT        verdict code: 00 none, 01 wrong, 11 correct
//   STATE         FSM state code for display/debug
//   TARGET        current target value from the problem table
//   SCORE         correct-answer count, saturating at 15
//   BUSY          high in every state except IDLE
interface factor_judge_if;
  logic       DEC;
  logic [3:0] D1;
  logic [3:0] D2;
  logic [3:0] D3;
  logic [1:0] RESULT;
  logic [3:0] STATE;
  logic [9:0] TARGET;
  logic [3:0] SCORE;
  logic       BUSY;

  modport master (
    output DEC, D1, D2, D3,
    input  RESULT, STATE, TARGET, SCORE, BUSY
  );

  modport slave (
    input  DEC, D1, D2, D3,
    output RESULT, STATE, TARGET, SCORE, BUSY
  );
endinterface

// File: rtl/factor_judge.sv
// factor_judge: answer-checking engine of the factorization game.
// On DEC in IDLE it captures three digits, multiplies them with a
// sequential shift-add multiplier (4 cycles per operand), compares the
// product with the current problem-table target and shows a verdict for
// HOLD_CYCLES cycles. Correct answers advance the table and the score.
// Ports:
//   CLK    system clock, rising edge
//   RST_N  asynchronous active-low reset
//   bus    factor_judge_if.slave (DEC, D1..D3 in; RESULT, STATE,
//          TARGET, SCORE, BUSY out)
module factor_judge #(
  parameter int unsigned HOLD_CYCLES = 50000000
) (
  input  logic           CLK,
  input  logic           RST_N,
  factor_judge_if.slave  bus
);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    CAPTURE = 4'd1,
    MUL1    = 4'd2,
    MUL2    = 4'd3,
    CHECK   = 4'd4,
    SHOW    = 4'd5,
    DONE    = 4'd6
  } state_t;

  // The hold counter only ever holds HOLD_CYCLES-1 down to 0.
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

  state_t            state_reg,  state_next;
  logic [3:0]        a1_reg,     a1_next;
  logic [3:0]        a2_reg,     a2_next;
  logic [3:0]        a3_reg,     a3_next;
  logic [9:0]        mcand_reg,  mcand_next;
  logic [9:0]        acc_reg,    acc_next;
  logic [1:0]        step_reg,   step_next;
  logic [2:0]        idx_reg,    idx_next;
  logic [3:0]        score_reg,  score_next;
  logic [1:0]        result_reg, result_next;
  logic [HOLD_W-1:0] hold_reg,   hold_next;

  logic [9:0] target;
  logic [9:0] addend;
  logic       digits_ok;

  function automatic logic digit_legal(input logic [3:0] d);
    return (d != 4'd0) && (d <= 4'd9);
  endfunction

  // Fixed problem table.
  always_comb begin
    case (idx_reg)
      3'd0:    target = 10'd12;
      3'd1:    target = 10'd30;
      3'd2:    target = 10'd42;
      3'd3:    target = 10'd60;
      3'd4:    target = 10'd105;
      3'd5:    target = 10'd168;
      3'd6:    target = 10'd210;
      default: target = 10'd504;
    endcase
  end

  assign digits_ok = digit_legal(a1_reg) && digit_legal(a2_reg) && digit_legal(a3_reg);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg  <= IDLE;
      a1_reg     <= '0;
      a2_reg     <= '0;
      a3_reg     <= '0;
      mcand_reg  <= '0;
      acc_reg    <= '0;
      step_reg   <= '0;
      idx_reg    <= '0;
      score_reg  <= '0;
      result_reg <= '0;
      hold_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      a1_reg     <= a1_next;
      a2_reg     <= a2_next;
      a3_reg     <= a3_next;
      mcand_reg  <= mcand_next;
      acc_reg    <= acc_next;
      step_reg   <= step_next;
      idx_reg    <= idx_next;
      score_reg  <= score_next;
      result_reg <= result_next;
      hold_reg   <= hold_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    a1_next     = a1_reg;
    a2_next     = a2_reg;
    a3_next     = a3_reg;
    mcand_next  = mcand_reg;
    acc_next    = acc_reg;
    step_next   = step_reg;
    idx_next    = idx_reg;
    score_next  = score_reg;
    result_next = result_reg;
    hold_next   = hold_reg;
    addend      = '0;

    case (state_reg)
      IDLE: begin
        if (bus.DEC) state_next = CAPTURE;
      end
      CAPTURE: begin
        // Entry block updated its digits on the DEC edge, so they are stable now.
        a1_next    = bus.D1;
        a2_next    = bus.D2;
        a3_next    = bus.D3;
        acc_next   = '0;
        mcand_next = '0;
        step_next  = '0;
        state_next = MUL1;
      end
      MUL1: begin
        if (a2_reg[step_reg]) addend = 10'(a1_reg) << step_reg;
        acc_next  = acc_reg + addend;
        step_next = step_reg + 2'd1;
        if (step_reg == 2'd3) begin
          // a1*a2 becomes the multiplicand of the second pass; the step
          // counter wraps to 0 on its own.
          mcand_next = acc_reg + addend;
          acc_next   = '0;
          state_next = MUL2;
        end
      end
      MUL2: begin
        if (a3_reg[step_reg]) addend = mcand_reg << step_reg;
        acc_next  = acc_reg + addend;
        step_next = step_reg + 2'd1;
        if (step_reg == 2'd3) state_next = CHECK;
      end
      CHECK: begin
        hold_next = HOLD_LOAD;
        if (digits_ok && (acc_reg == target)) begin
          result_next = 2'b11;
          if (score_reg != 4'd15) score_next = score_reg + 4'd1;
          if (idx_reg == 3'd7) begin
            state_next = DONE;
          end else begin
            idx_next   = idx_reg + 3'd1;
            state_next = SHOW;
          end
        end else begin
          result_next = 2'b01;
          state_next  = SHOW;
        end
      end
      SHOW: begin
        if (hold_reg == '0) begin
          result_next = 2'b00;
          state_next  = IDLE;
        end else begin
          hold_next = hold_reg - 1'b1;
        end
      end
      DONE: begin
        // Terminal until reset.
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.RESULT = result_reg;
  assign bus.STATE  = state_reg;
  assign bus.TARGET = target;
  assign bus.SCORE  = score_reg;
  assign bus.BUSY   = (state_reg != IDLE);

endmodule

// File: tb/tb_factor_judge.sv
// tb_factor_judge: directed plus randomized bench for factor_judge with
// HOLD_CYCLES=4. A small reference model (problem table, index, score)
// predicts every verdict from plain arithmetic on the digits.
module tb_factor_judge;
  localparam int HOLD = 4;

  logic clk;
  logic rst_n;
  factor_judge_if bus ();

  factor_judge #(.HOLD_CYCLES(HOLD)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int tbl[8]    = '{12, 30, 42, 60, 105, 168, 210, 504};
  int sol[8][3] = '{'{2,2,3}, '{2,3,5}, '{2,3,7}, '{3,4,5},
                    '{3,5,7}, '{3,7,8}, '{5,6,7}, '{7,8,9}};
  int m_idx;
  int m_score;
  bit m_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_idx = 0;
    m_score = 0;
    m_done = 0;
  endtask

  // One full evaluation; poke raises DEC once in MUL1 and once in SHOW.
  task automatic run_eval(input int d1, input int d2, input int d3, input bit poke);
    int  prod;
    bit  ok;
    int  old_target;
    int  exp_state;
    prod = (d1 * d2 * d3) % 1024;
    ok = (d1 >= 1 && d1 <= 9) && (d2 >= 1 && d2 <= 9) && (d3 >= 1 && d3 <= 9)
         && (prod == tbl[m_idx]);
    old_target = tbl[m_idx];
    if (ok) begin
      if (m_score < 15) m_score++;
      if (m_idx == 7) m_done = 1;
      else m_idx++;
    end
    $display("eval D=%0d,%0d,%0d target=%0d -> expect %s", d1, d2, d3, old_target,
             ok ? "correct" : "wrong");
    bus.D1 = 4'(d1);
    bus.D2 = 4'(d2);
    bus.D3 = 4'(d3);
    bus.DEC = 1'b1;
    tick();
    bus.DEC = 1'b0;
    chk("cap_state", bus.STATE, 1);
    chk("cap_busy", bus.BUSY, 1);
    for (int i = 1; i <= 9; i++) begin
      if (poke && i == 2) bus.DEC = 1'b1;
      tick();
      bus.DEC = 1'b0;
      exp_state = (i <= 4) ? 2 : (i <= 8) ? 3 : 4;
      chk("seq_state", bus.STATE, exp_state);
      chk("pend_result", bus.RESULT, 0);
      chk("pend_target", bus.TARGET, old_target);
    end
    tick();
    chk("verdict", bus.RESULT, ok ? 3 : 1);
    chk("verdict_target", bus.TARGET, tbl[m_idx]);
    chk("verdict_score", bus.SCORE, m_score);
    chk("verdict_state", bus.STATE, m_done ? 6 : 5);
    if (!m_done) begin
      for (int h = 1; h < HOLD; h++) begin
        if (poke && h == 1) bus.DEC = 1'b1;
        tick();
        bus.DEC = 1'b0;
        chk("hold_result", bus.RESULT, ok ? 3 : 1);
        chk("hold_state", bus.STATE, 5);
      end
      tick();
      chk("end_result", bus.RESULT, 0);
      chk("end_state", bus.STATE, 0);
      chk("end_busy", bus.BUSY, 0);
    end
  endtask

  initial begin
    int r1, r2, r3, guard, rot, tmp;
    int p[3];
    rst_n = 1'b0;
    bus.DEC = 1'b0;
    bus.D1 = '0;
    bus.D2 = '0;
    bus.D3 = '0;
    model_reset();
    repeat (3) tick();
    chk("rst_state", bus.STATE, 0);
    chk("rst_result", bus.RESULT, 0);
    chk("rst_target", bus.TARGET, 12);
    chk("rst_score", bus.SCORE, 0);
    chk("rst_busy", bus.BUSY, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_state", bus.STATE, 0);

    // Wrong answers and illegal digits at target 12.
    run_eval(1, 1, 9, 1'b0);
    run_eval(12, 1, 1, 1'b0);
    run_eval(0, 5, 5, 1'b0);
    // Correct answer with DEC pokes in MUL1 and SHOW.
    run_eval(2, 2, 3, 1'b1);

    // Rest of the table: a random attempt then a known factorization.
    guard = 0;
    while (!m_done && guard < 20) begin
      r1 = $urandom_range(0, 15);
      r2 = $urandom_range(0, 15);
      r3 = $urandom_range(0, 15);
      run_eval(r1, r2, r3, 1'($urandom_range(0, 1)));
      if (!m_done) begin
        p[0] = sol[m_idx][0];
        p[1] = sol[m_idx][1];
        p[2] = sol[m_idx][2];
        rot = $urandom_range(0, 2);
        tmp = p[0];
        p[0] = p[rot];
        p[rot] = tmp;
        run_eval(p[0], p[1], p[2], 1'b0);
      end
      guard++;
    end
    chk("full_run_done", 32'(m_done), 1);
    chk("done_score", bus.SCORE, 8);
    chk("done_state", bus.STATE, 6);

    // DONE ignores DEC and holds its outputs.
    bus.DEC = 1'b1;
    tick();
    bus.DEC = 1'b0;
    repeat (12) tick();
    chk("done_hold_state", bus.STATE, 6);
    chk("done_hold_result", bus.RESULT, 3);
    chk("done_hold_target", bus.TARGET, 504);
    chk("done_hold_score", bus.SCORE, 8);

    // Asynchronous reset between edges.
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    $display("async reset asserted mid-cycle");
    chk("arst_state", bus.STATE, 0);
    chk("arst_result", bus.RESULT, 0);
    chk("arst_target", bus.TARGET, tbl[m_idx]);
    chk("arst_score", bus.SCORE, m_score);
    chk("arst_busy", bus.BUSY, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("arst_idle", bus.STATE, 0);

    // Reset during MUL2 aborts the evaluation.
    $display("eval D=2,2,3 aborted by reset in MUL2");
    bus.D1 = 4'd2;
    bus.D2 = 4'd2;
    bus.D3 = 4'd3;
    bus.DEC = 1'b1;
    tick();
    bus.DEC = 1'b0;
    repeat (6) tick();
    chk("abort_in_mul2", bus.STATE, 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_state", bus.STATE, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("abort_no_verdict", bus.RESULT, 0);
      chk("abort_idle", bus.STATE, 0);
    end
    chk("abort_score", bus.SCORE, 0);
    chk("abort_target", bus.TARGET, 12);

    // Fresh evaluation still works after the abort.
    run_eval(3, 2, 2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
